// File: rtl/note_pkg.sv
// Shared definitions for the buzzer audio path: note index width, decoder FSM states
// and the diatonic C4..B6 tone table used by both the tone generator and the detector.
package note_pkg;

    localparam int NOTE_W    = 5;
    localparam int NUM_NOTES = 21;
    localparam logic [NOTE_W-1:0] NOTE_SILENCE = '0;
    localparam logic [NOTE_W-1:0] NOTE_LAST    = NOTE_W'(NUM_NOTES);

    typedef enum logic [1:0] {IDLE, SEARCH, DECIDE} state_t;

    // Tone frequencies in milli-hertz; index 1 = C4 .. index 21 = B6, anything else is silence.
    function automatic int unsigned note_mhz(input int unsigned idx);
        case (idx)
            1:  return 261626;
            2:  return 293665;
            3:  return 329628;
            4:  return 349228;
            5:  return 392000;
            6:  return 440000;
            7:  return 493883;
            8:  return 523251;
            9:  return 587330;
            10: return 659255;
            11: return 698456;
            12: return 783991;
            13: return 880000;
            14: return 987767;
            15: return 1046502;
            16: return 1174659;
            17: return 1318510;
            18: return 1396913;
            19: return 1567982;
            20: return 1760000;
            21: return 1975533;
            default: return 0;
        endcase
    endfunction

    // round(clk_hz / f); evaluated only with constant arguments, so it folds to a table.
    function automatic longint unsigned nominal_period(input longint unsigned clk_hz,
                                                       input int unsigned idx);
        longint unsigned f_mhz;
        f_mhz = 64'(note_mhz(idx));
        if (f_mhz == 64'd0) return 64'd0;
        return (clk_hz * 64'd1000 + f_mhz / 64'd2) / f_mhz;
    endfunction

endpackage

// File: rtl/note_period_lut.sv
// Combinational note index -> nominal tone period in clk cycles (0 for silence/out of range).
module note_period_lut
    import note_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int          PERIOD_W = 20
) (
    input  logic [NOTE_W-1:0]   idx,
    output logic [PERIOD_W-1:0] nominal
);

    logic [PERIOD_W-1:0] lut [0:2**NOTE_W-1];

    for (genvar i = 0; i < 2**NOTE_W; i++) begin : g_entry
        assign lut[i] = PERIOD_W'(nominal_period(64'(CLK_HZ), i));
    end

    assign nominal = lut[idx];

endmodule

// File: rtl/note_detector.sv
// Measures the period of the incoming buzzer square wave and decodes it to a confirmed
// note index, with silence detection by timeout and CONFIRM-deep debouncing of changes.
module note_detector
    import note_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int          PERIOD_W  = 20,
    parameter int          TOL_SHIFT = 5,
    parameter int          CONFIRM   = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                spk_in,
    output logic [NOTE_W-1:0]   note,
    output logic                note_valid,
    output logic                note_change,
    output logic [PERIOD_W-1:0] period
);

    localparam int CNT_W = $clog2(CONFIRM + 1);
    localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

    logic                sync1, sync2, spk_prev;
    logic                rise, armed, timeout, measure;
    logic [PERIOD_W-1:0] cnt, span, meas, nominal;
    logic [PERIOD_W:0]   diff;
    logic                in_tol;

    state_t              state;
    logic [NOTE_W-1:0]   idx, result, candidate;
    logic [CNT_W-1:0]    count;
    logic [NOTE_W-1:0]   dec_cand;
    logic [CNT_W-1:0]    dec_count;
    logic                dec_commit;

    assign rise    = sync2 & ~spk_prev;
    assign timeout = (cnt == CNT_MAX);
    assign span    = cnt + 1'b1;
    assign measure = rise & armed & ~timeout;

    // NOTE: sequential state uses non-blocking assignments only, so every block sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            spk_prev <= 1'b0;
            cnt      <= '0;
            armed    <= 1'b0;
            period   <= '0;
        end else begin
            sync1    <= spk_in;
            sync2    <= sync1;
            spk_prev <= sync2;
            if (rise) begin
                cnt   <= '0;
                armed <= 1'b1;
                if (measure) period <= span;
            end else if (timeout) begin
                armed <= 1'b0;
            end else begin
                cnt <= span;
            end
        end
    end

    note_period_lut #(
        .CLK_HZ   (CLK_HZ),
        .PERIOD_W (PERIOD_W)
    ) u_lut (
        .idx     (idx),
        .nominal (nominal)
    );

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        diff = '0;
        if (meas >= nominal) diff = {1'b0, meas} - {1'b0, nominal};
        else                 diff = {1'b0, nominal} - {1'b0, meas};
        in_tol = (diff <= {1'b0, (nominal >> TOL_SHIFT)});

        dec_cand  = result;
        dec_count = CNT_W'(1);
        if (result == candidate) begin
            dec_cand  = candidate;
            dec_count = (count >= CNT_W'(CONFIRM)) ? CNT_W'(CONFIRM) : count + 1'b1;
        end
        dec_commit = (dec_count == CNT_W'(CONFIRM)) && (dec_cand != note);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            idx         <= '0;
            meas        <= '0;
            result      <= '0;
            candidate   <= '0;
            count       <= '0;
            note        <= NOTE_SILENCE;
            note_valid  <= 1'b0;
            note_change <= 1'b0;
        end else begin
            note_change <= 1'b0;
            if (timeout) begin
                // Silence overrides any decode in flight, including a same-cycle DECIDE.
                state     <= IDLE;
                candidate <= '0;
                count     <= '0;
                if (note != NOTE_SILENCE) begin
                    note        <= NOTE_SILENCE;
                    note_valid  <= 1'b0;
                    note_change <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (measure) begin
                            meas  <= span;
                            idx   <= NOTE_W'(1);
                            state <= SEARCH;
                        end
                    end
                    SEARCH: begin
                        if (in_tol) begin
                            result <= idx;
                            state  <= DECIDE;
                        end else if (idx == NOTE_LAST) begin
                            result <= NOTE_SILENCE;
                            state  <= DECIDE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    DECIDE: begin
                        candidate <= dec_cand;
                        count     <= dec_count;
                        if (dec_commit) begin
                            note        <= dec_cand;
                            note_valid  <= (dec_cand != NOTE_SILENCE);
                            note_change <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_detector.sv
// Scoreboard bench for note_detector: stimulus pushes expected note changes from a
// period-level reference model; a negedge monitor pops them whenever note_change pulses.
module tb_note_detector;

    localparam int CLK_HZ      = 500_000;
    localparam int PERIOD_W    = 12;
    localparam int CONFIRM     = 3;
    localparam int CLK_NS      = 10;
    localparam int SYNC_LAT    = 3;
    localparam int TIMEOUT_CYC = 2**PERIOD_W - 1;

    logic                clk;
    logic                reset_n;
    logic                spk_in;
    logic [4:0]          note;
    logic                note_valid;
    logic                note_change;
    logic [PERIOD_W-1:0] period;

    logic [4:0]          lut_idx;
    logic [19:0]         lut_nom;

    note_detector #(
        .CLK_HZ    (CLK_HZ),
        .PERIOD_W  (PERIOD_W),
        .TOL_SHIFT (5),
        .CONFIRM   (CONFIRM)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .spk_in      (spk_in),
        .note        (note),
        .note_valid  (note_valid),
        .note_change (note_change),
        .period      (period)
    );

    // Full-rate table instance, compared against the 50 MHz anchor periods.
    note_period_lut #(
        .CLK_HZ   (50_000_000),
        .PERIOD_W (20)
    ) u_lut_ref (
        .idx     (lut_idx),
        .nominal (lut_nom)
    );

    initial clk = 1'b0;
    always #(CLK_NS/2) clk = ~clk;

    typedef struct {
        int  note;
        int  per;
        time at;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_fail = 0;

    real  note_hz [21] = '{261.626, 293.665, 329.628, 349.228, 392.000, 440.000, 493.883,
                           523.251, 587.330, 659.255, 698.456, 783.991, 880.000, 987.767,
                           1046.502, 1174.659, 1318.510, 1396.913, 1567.982, 1760.000, 1975.533};
    int   nom [1:21];
    int   ref_idx [6] = '{1, 5, 9, 21, 0, 22};
    int   ref_val [6] = '{191113, 127551, 85131, 25310, 0, 0};

    int   m_note, m_period, m_last;
    bit   m_armed;
    time  m_rise_t;
    int   hist[$];
    int   stim_now;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic int decode(input int m);
        int d;
        for (int i = 1; i <= 21; i++) begin
            d = (m > nom[i]) ? m - nom[i] : nom[i] - m;
            if (d <= nom[i] / 32) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_note   = 0;
        m_period = 0;
        m_armed  = 1'b0;
        hist.delete();
    endtask

    task automatic model_rise();
        int  r;
        bit  same;
        if (!m_armed) begin
            m_armed = 1'b1;
        end else begin
            m_period = stim_now - m_last;
            r = decode(m_period);
            hist.push_back(r);
            if (hist.size() > CONFIRM) void'(hist.pop_front());
            same = (hist.size() == CONFIRM);
            foreach (hist[k]) if (hist[k] != r) same = 1'b0;
            if (same && r != m_note) begin
                m_note = r;
                exp_q.push_back('{r, m_period, 0});
            end
        end
        m_last   = stim_now;
        m_rise_t = $time;
    endtask

    // One period of the tone: rising edge, high half, low half.
    task automatic tone(input int p);
        @(posedge clk);
        #1;
        spk_in = 1'b1;
        model_rise();
        repeat (p / 2) @(posedge clk);
        #1;
        spk_in = 1'b0;
        repeat (p - p / 2 - 1) @(posedge clk);
        stim_now += p;
    endtask

    task automatic silence(input int n);
        if (m_armed && (stim_now + n - m_last) >= 2**PERIOD_W) begin
            m_armed = 1'b0;
            hist.delete();
            if (m_note != 0) begin
                m_note = 0;
                exp_q.push_back('{0, m_period,
                    (m_rise_t - 1) + time'((SYNC_LAT + TIMEOUT_CYC + 1) * CLK_NS + CLK_NS / 2)});
            end
        end
        repeat (n) @(posedge clk);
        stim_now += n;
    endtask

    task automatic checkpoint(input string tag);
        @(negedge clk);
        check({tag, "_note"},   note,       m_note);
        check({tag, "_valid"},  note_valid, m_note != 0);
        check({tag, "_period"}, period,     m_period);
    endtask

    always @(negedge clk) begin
        if (reset_n && note_change) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_pulse: note_change with note=%0d, no change required", note);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_note",   note,       mon_e.note);
                check("pulse_valid",  note_valid, mon_e.note != 0);
                check("pulse_period", period,     mon_e.per);
                if (mon_e.at != 0) check("timeout_pulse_time", $time, mon_e.at);
            end
        end
    end

    initial begin
        #(150_000 * CLK_NS);
        $display("FAIL watchdog: run exceeded 150000 clk");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p, tol, kind, reps, n_idx;
        spk_in   = 1'b0;
        reset_n  = 1'b0;
        lut_idx  = '0;
        stim_now = 0;
        m_last   = 0;
        m_rise_t = 0;
        model_reset();
        for (int i = 1; i <= 21; i++) nom[i] = $rtoi(real'(CLK_HZ) / note_hz[i-1] + 0.5);

        for (int i = 0; i < 6; i++) begin
            lut_idx = 5'(ref_idx[i]);
            #1;
            check($sformatf("lut50m_idx%0d", ref_idx[i]), lut_nom, ref_val[i]);
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_note",   note,        0);
        check("rst_valid",  note_valid,  0);
        check("rst_change", note_change, 0);
        check("rst_period", period,      0);
        reset_n = 1'b1;

        // Idle past a full timeout: nothing may happen.
        silence(2**PERIOD_W + 100);
        checkpoint("idle");

        // Arming edge plus three measured edges locks note 5.
        repeat (4) tone(nom[5]);
        checkpoint("lock5");

        // Jitter at the tolerance limits holds the note; one sample just outside does not move it.
        tol = nom[5] / 32;
        for (int i = 0; i < 4; i++) tone((i % 2 == 0) ? nom[5] + tol : nom[5] - tol);
        tone(nom[5] + tol + 1);
        tone(nom[5]);
        checkpoint("jitter5");

        // Switch to note 9, then to an off-table period.
        repeat (3) tone(nom[9]);
        checkpoint("hold5");
        tone(nom[9]);
        checkpoint("lock9");
        repeat (4) tone(1070);
        checkpoint("unknown");

        // Re-lock 9, go silent until timeout, then a fresh arming edge is needed.
        repeat (4) tone(nom[9]);
        checkpoint("relock9");
        silence(5000);
        checkpoint("timeout");
        repeat (3) tone(nom[9]);
        checkpoint("rearm_hold");
        tone(nom[9]);
        checkpoint("rearm_lock");

        // Build count=2 toward note 5, then reset during the search of the confirming edge.
        repeat (3) tone(nom[5]);
        checkpoint("confirm2");
        check("queue_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
        spk_in = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("midreset_note",   note,        0);
        check("midreset_valid",  note_valid,  0);
        check("midreset_change", note_change, 0);
        check("midreset_period", period,      0);
        spk_in = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) tone(nom[5]);
        checkpoint("post_reset_hold");
        tone(nom[5]);
        checkpoint("post_reset_lock");

        // Random groups: in-tolerance note periods and arbitrary periods.
        for (int g = 0; g < 10 && stim_now < 85_000; g++) begin
            kind  = $urandom_range(0, 3);
            reps  = $urandom_range(1, 3);
            n_idx = $urandom_range(1, 21);
            for (int r = 0; r < reps; r++) begin
                if (kind != 0) begin
                    tol = nom[n_idx] / 32;
                    p   = nom[n_idx] - tol + $urandom_range(0, 2 * tol);
                end else begin
                    p = $urandom_range(260, 1400);
                end
                tone(p);
            end
            checkpoint($sformatf("rand%0d", g));
        end

        repeat (40) @(posedge clk);
        check("expect_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
